// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared state and reference-mode definitions for the gate sweeper
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_t;

  localparam int MODE_AND = 0;
  localparam int MODE_OR  = 1;
  localparam int MODE_XOR = 2;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational reduction reference for an N-input gate
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int MODE = MODE_AND
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp
);

  always_comb begin
    case (MODE)
      MODE_OR:  exp = |vec;
      MODE_XOR: exp = ^vec;
      default:  exp = &vec;
    endcase
  end

endmodule

// File: rtl/gate_vector_sweeper.sv
// rtl/gate_vector_sweeper.sv - sweeps all input vectors onto a gate and checks each sample
module gate_vector_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 5,
  parameter int MODE        = MODE_AND
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] in_vec,
  output logic            vec_valid,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  state_t            state_q;
  logic [HW-1:0]     hold_cnt_q;
  logic [N_IN-1:0]   in_vec_q;
  logic [N_IN-1:0]   first_fail_q;
  logic [N_IN:0]     err_cnt_q;
  logic              vec_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic              exp_y;
  logic              sample_d;
  logic              mismatch_d;
  logic [N_IN:0]     err_cnt_d;

  gate_ref_model #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_ref (
    .vec (in_vec_q),
    .exp (exp_y)
  );

  // Case inequality so an undriven or X gate output counts as a failure in simulation.
  always_comb begin
    sample_d   = (state_q == ST_DRIVE) && (hold_cnt_q == HOLD_LAST);
    mismatch_d = sample_d && (dut_y !== exp_y);
    err_cnt_d  = err_cnt_q + {{N_IN{1'b0}}, mismatch_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      in_vec_q     <= '0;
      first_fail_q <= '0;
      err_cnt_q    <= '0;
      vec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_DRIVE;
            hold_cnt_q   <= '0;
            in_vec_q     <= '0;
            first_fail_q <= '0;
            err_cnt_q    <= '0;
            vec_valid_q  <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        ST_DRIVE: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (sample_d) begin
            err_cnt_q <= err_cnt_d;
            if (mismatch_d && (err_cnt_q == '0)) first_fail_q <= in_vec_q;
            // Terminal check comes before the increment, so in_vec never wraps.
            if (in_vec_q == VEC_LAST) begin
              state_q     <= ST_DONE;
              vec_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              pass_q      <= (err_cnt_d == '0);
            end else begin
              in_vec_q   <= in_vec_q + 1'b1;
              hold_cnt_q <= '0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_vec     = in_vec_q;
  assign vec_valid  = vec_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_vector_sweeper.sv
// tb/tb_gate_vector_sweeper.sv - self-checking bench for gate_vector_sweeper
module tb_gate_vector_sweeper;

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic [7:0] gate_tt;
  logic       dut_y, dut2_y;
  logic [2:0] in_vec, first_fail, in_vec2, first_fail2;
  logic [3:0] err_cnt, err_cnt2;
  logic       vec_valid, busy, done, pass;
  logic       vec_valid2, busy2, done2, pass2;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  always #5 clk = ~clk;

  // Gate under test is a truth table so faulty gates are just different tables.
  assign dut_y  = gate_tt[in_vec];
  assign dut2_y = ^in_vec2;

  gate_vector_sweeper #(.N_IN(3), .HOLD_CYCLES(5), .MODE(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_y(dut_y),
    .in_vec(in_vec), .vec_valid(vec_valid), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_fail(first_fail)
  );

  gate_vector_sweeper #(.N_IN(3), .HOLD_CYCLES(1), .MODE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_y(dut2_y),
    .in_vec(in_vec2), .vec_valid(vec_valid2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err_cnt2), .first_fail(first_fail2)
  );

  always @(negedge clk) begin
    if ((vec_valid && (!busy || done)) || (vec_valid2 && (!busy2 || done2))) viol++;
  end

  typedef struct {
    logic [7:0] tt;
    int         err;
    int         ff;
    bit         pass;
    bit         mid;
    string      tag;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: AND expects 1 only for the all-ones vector; walk vectors in order.
  function automatic void model(input logic [7:0] tt, output int err, output int ff);
    bit e;
    err = 0;
    ff  = 0;
    for (int v = 0; v < 8; v++) begin
      e = (v == 7);
      if (tt[v] !== e) begin
        if (err == 0) ff = v;
        err++;
      end
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_sweep(input logic [7:0] tt, input int e_err, input int e_ff,
                           input bit e_pass, input bit mid, input string tag);
    int n;
    bit ok;
    logic [2:0] seen[$];
    gate_tt = tt;
    pulse_start();
    chk({tag, " start_clear"}, {18'd0, err_cnt, first_fail, done, pass, in_vec, vec_valid, busy},
        {18'd0, 4'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1});
    n = 0;
    seen.delete();
    while (!done && n < 200) begin
      if (vec_valid) seen.push_back(in_vec);
      start = mid && (n == 15);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, n, 40);
    ok = (seen.size() == 40);
    for (int i = 0; i < seen.size(); i++) if (seen[i] != 3'(i / 5)) ok = 1'b0;
    chk({tag, " vec_seq"}, ok, 1);
    chk({tag, " err_cnt"}, err_cnt, e_err);
    chk({tag, " first_fail"}, first_fail, e_ff);
    chk({tag, " pass"}, pass, e_pass);
    chk({tag, " idle_outs"}, {busy, vec_valid, in_vec}, {1'b0, 1'b0, 3'd7});
  endtask

  initial begin
    vec_t tbl[5];
    int e_err, e_ff, n;
    bit ok;
    logic [7:0] tt;
    logic [2:0] seen2[$];

    tbl[0] = '{8'h80, 0, 0, 1'b1, 1'b0, "and_good"};
    tbl[1] = '{8'hFE, 6, 1, 1'b0, 1'b0, "or_gate"};
    tbl[2] = '{8'hFF, 7, 0, 1'b0, 1'b0, "stuck1"};
    tbl[3] = '{8'h00, 1, 7, 1'b0, 1'b0, "stuck0"};
    tbl[4] = '{8'h80, 0, 0, 1'b1, 1'b1, "mid_start"};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; gate_tt = 8'h80;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {busy, done, pass, vec_valid, err_cnt, first_fail, in_vec},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0});

    // rst in the middle of a sweep clears everything, then a fresh sweep starts at 0
    pulse_start();
    repeat (12) @(negedge clk);
    chk("mid_sweep_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_mid_sweep", {busy, done, pass, vec_valid, err_cnt, first_fail, in_vec},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0});

    for (int i = 0; i < 5; i++)
      run_sweep(tbl[i].tt, tbl[i].err, tbl[i].ff, tbl[i].pass, tbl[i].mid, tbl[i].tag);

    for (int i = 0; i < 6; i++) begin
      tt = 8'($urandom_range(0, 255));
      model(tt, e_err, e_ff);
      run_sweep(tt, e_err, e_ff, (e_err == 0), 1'b0, "random");
    end

    // start coinciding with the DRIVE->DONE edge is ignored
    gate_tt = 8'h80;
    pulse_start();
    repeat (39) @(negedge clk);
    chk("last_vec_held", {vec_valid, in_vec}, {1'b1, 3'd7});
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_at_done_edge", {done, busy, vec_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("still_done", {done, busy, vec_valid, pass}, {1'b1, 1'b0, 1'b0, 1'b1});

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", {busy, done, pass, vec_valid, err_cnt, first_fail, in_vec},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0});

    // HOLD_CYCLES=1, XOR reference against an XOR gate
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    seen2.delete();
    while (!done2 && n < 100) begin
      if (vec_valid2) seen2.push_back(in_vec2);
      @(negedge clk);
      n++;
    end
    chk("xor_done_cycle", n, 8);
    ok = (seen2.size() == 8);
    for (int i = 0; i < seen2.size(); i++) if (seen2[i] != 3'(i)) ok = 1'b0;
    chk("xor_vec_seq", ok, 1);
    chk("xor_result", {pass2, err_cnt2, first_fail2}, {1'b1, 4'd0, 3'd0});

    chk("no_valid_outside_drive", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
